// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Purpose  : Instruction fetch. Owns the PC, keeps one imem request in
//             flight, and registers {pc, pc+4, instr, valid} for IF/ID.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_4,
    output logic [31:0] if_instruction
);

    localparam logic [31:0] C_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        valid_q, valid_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_pc4_q, slot_pc4_d;
    logic [31:0] slot_instr_q, slot_instr_d;

    logic        w_consume;
    logic        w_resp_owed;
    logic [31:0] w_redirect_target;

    assign w_consume         = valid_q && !stall;
    assign w_redirect_target = redirect_pc & ~32'd3;
    assign w_resp_owed       = ((state_q == ST_WAIT)  && !imem_rvalid) ||
                               ((state_q == ST_FETCH) &&  imem_gnt)    ||
                               ((state_q == ST_DRAIN) && !imem_rvalid);

    // The skid entry is full exactly while in HOLD; its PC is req_pc_q since
    // no new request is issued until the skid drains.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_instr_d = skid_instr_q;
        valid_d      = valid_q;
        slot_pc_d    = slot_pc_q;
        slot_pc4_d   = slot_pc4_q;
        slot_instr_d = slot_instr_q;

        if (w_consume) begin
            valid_d      = 1'b0;
            slot_instr_d = NOP_INSTR;
        end

        case (state_q)
            ST_FETCH: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + C_PC_STEP;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (!valid_q || w_consume) begin
                        valid_d      = 1'b1;
                        slot_pc_d    = req_pc_q;
                        slot_pc4_d   = req_pc_q + C_PC_STEP;
                        slot_instr_d = imem_rdata;
                        state_d      = ST_FETCH;
                    end else begin
                        skid_instr_d = imem_rdata;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_consume) begin
                    valid_d      = 1'b1;
                    slot_pc_d    = req_pc_q;
                    slot_pc4_d   = req_pc_q + C_PC_STEP;
                    slot_instr_d = skid_instr_q;
                    state_d      = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Redirect overrides everything above; a request still in flight is
        // tracked through DRAIN so its response gets dropped.
        if (redirect) begin
            pc_d         = w_redirect_target;
            valid_d      = 1'b0;
            slot_instr_d = NOP_INSTR;
            state_d      = w_resp_owed ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            valid_q      <= 1'b0;
            slot_pc_q    <= 32'd0;
            slot_pc4_q   <= 32'd0;
            slot_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_instr_q <= skid_instr_d;
            valid_q      <= valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_pc4_q   <= slot_pc4_d;
            slot_instr_q <= slot_instr_d;
        end
    end

    assign imem_req       = (state_q == ST_FETCH);
    assign imem_addr      = pc_q;
    assign if_valid       = valid_q;
    assign if_pc          = slot_pc_q;
    assign if_pc_plus_4   = slot_pc4_q;
    assign if_instruction = slot_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Purpose  : Self-checking bench for if_fetch_stage (directed + random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instruction;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        pend;
    logic [31:0] pend_addr;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_instruction (if_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst  = 1'b1;
        pend = 1'b0;
        repeat (2) tick();
        rst  = 1'b0;
    endtask

    // Well-behaved memory: grant when enabled, answer one cycle after grant.
    task automatic mem_cycle(input logic gnt_en);
        imem_gnt    = imem_req && gnt_en;
        imem_rvalid = pend;
        imem_rdata  = pend ? mem_word(pend_addr) : 32'd0;
        if (imem_rvalid) pend = 1'b0;
        if (imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
        end
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst  = 1'b1;
        pend = 1'b0;
        repeat (2) tick();
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        tests_run++; if (if_pc !== 32'd0) begin tests_failed++; $display("FAIL rst_pc: got %h expected 0", if_pc); end
        tests_run++; if (if_pc_plus_4 !== 32'd0) begin tests_failed++; $display("FAIL rst_pc4: got %h expected 0", if_pc_plus_4); end
        tests_run++; if (if_instruction !== NOP) begin tests_failed++; $display("FAIL rst_instr: got %h expected %h", if_instruction, NOP); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin tests_failed++; $display("FAIL rst_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_stream;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tests_run++;
            if (imem_req !== (c % 2 == 0)) begin tests_failed++; $display("FAIL stream_req c=%0d: got %b", c, imem_req); end
            if (c % 2 == 0) begin
                tests_run++;
                if (imem_addr !== 32'(c * 2)) begin tests_failed++; $display("FAIL stream_addr c=%0d: got %h expected %h", c, imem_addr, 32'(c * 2)); end
            end
            tests_run++;
            if (if_valid !== (c >= 2 && c % 2 == 0)) begin tests_failed++; $display("FAIL stream_valid c=%0d: got %b", c, if_valid); end
            if (c >= 2 && c % 2 == 0) begin
                tests_run++;
                if (if_pc !== 32'((c - 2) * 2) || if_pc_plus_4 !== 32'((c - 2) * 2 + 4) || if_instruction !== mem_word(32'((c - 2) * 2))) begin
                    tests_failed++;
                    $display("FAIL stream_slot c=%0d: got pc=%h pc4=%h instr=%h expected pc=%h", c, if_pc, if_pc_plus_4, if_instruction, 32'((c - 2) * 2));
                end
            end
            mem_cycle(1'b1);
        end
    endtask

    task automatic test_stall_skid;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            stall = (c >= 2 && c <= 7);
            if (c >= 4 && c <= 8) begin
                tests_run++;
                if (if_valid !== 1'b1 || if_pc !== 32'd0 || imem_req !== (c == 8 ? 1'b0 : 1'b0)) begin
                    tests_failed++;
                    $display("FAIL skid_hold c=%0d: got valid=%b pc=%h req=%b expected valid=1 pc=0 req=0", c, if_valid, if_pc, imem_req);
                end
            end
            if (c == 9) begin
                tests_run++;
                if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instruction !== mem_word(32'd4) || imem_req !== 1'b1 || imem_addr !== 32'd8) begin
                    tests_failed++;
                    $display("FAIL skid_release: got valid=%b pc=%h instr=%h req=%b addr=%h expected pc=4 addr=8", if_valid, if_pc, if_instruction, imem_req, imem_addr);
                end
            end
            mem_cycle(1'b1);
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_wait;
        do_reset();
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; tick();
        redirect = 1'b0;
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rdw_drain_req: got %b expected 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
        imem_rvalid = 1'b0;
        tests_run++;
        if (if_valid !== 1'b0 || if_instruction !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL rdw_dropped: got valid=%b instr=%h req=%b addr=%h expected 0/%h/1/100", if_valid, if_instruction, imem_req, imem_addr, NOP);
        end
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093; tick();
        imem_rvalid = 1'b0;
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instruction !== 32'h0010_0093) begin
            tests_failed++;
            $display("FAIL rdw_target: got valid=%b pc=%h instr=%h expected 1/100/00100093", if_valid, if_pc, if_instruction);
        end
    endtask

    task automatic test_redirect_gnt;
        do_reset();
        imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h203; tick();
        imem_gnt = 1'b0; redirect = 1'b0;
        tests_run++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL rdg_drain: got req=%b valid=%b expected 0/0", imem_req, if_valid); end
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'd0); tick();
        imem_rvalid = 1'b0;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdg_refetch: got req=%b addr=%h valid=%b expected 1/200/0", imem_req, imem_addr, if_valid);
        end
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; tick();
        imem_rvalid = 1'b0;
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_pc_plus_4 !== 32'h204 || if_instruction !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL rdg_target: got valid=%b pc=%h pc4=%h instr=%h expected 1/200/204/12345678", if_valid, if_pc, if_pc_plus_4, if_instruction);
        end
    endtask

    task automatic test_gnt_delay_reset;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin tests_failed++; $display("FAIL gdly_stable c=%0d: got req=%b addr=%h expected 1/0", c, imem_req, imem_addr); end
            tick();
        end
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_word(32'd0); tick();
        imem_rvalid = 1'b0; stall = 1'b1;
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin tests_failed++; $display("FAIL gdly_first: got valid=%b pc=%h expected 1/0", if_valid, if_pc); end
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; stall = 1'b0;
        tests_run++;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_pc_plus_4 !== 32'd0 || if_instruction !== NOP || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL gdly_rst: got valid=%b pc=%h pc4=%h instr=%h req=%b addr=%h", if_valid, if_pc, if_pc_plus_4, if_instruction, imem_req, imem_addr);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD; tick();
        imem_rvalid = 1'b0;
        tests_run++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL gdly_late_rvalid: got valid=%b req=%b addr=%h expected 0/1/0", if_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
        redirect = 1'b0;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1/fffffffc", imem_req, imem_addr); end
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001; tick();
        imem_rvalid = 1'b0;
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc_plus_4 !== 32'd0 || if_instruction !== 32'hAAAA_0001 || imem_addr !== 32'd0) begin
            tests_failed++;
            $display("FAIL wrap_slot: got valid=%b pc=%h pc4=%h instr=%h addr=%h expected 1/fffffffc/0/aaaa0001/0", if_valid, if_pc, if_pc_plus_4, if_instruction, imem_addr);
        end
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0002; tick();
        imem_rvalid = 1'b0;
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_pc_plus_4 !== 32'd4 || if_instruction !== 32'hAAAA_0002) begin
            tests_failed++;
            $display("FAIL wrap_next: got valid=%b pc=%h pc4=%h instr=%h expected 1/0/4/aaaa0002", if_valid, if_pc, if_pc_plus_4, if_instruction);
        end
    endtask

    // Architectural model: consumed instructions must follow program order
    // (pc += 4, or the redirect target) and carry the memory word at that pc.
    task automatic test_random;
        logic [31:0] exp_pc;
        int          consumed;
        exp_pc   = 32'd0;
        consumed = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            stall       = (($urandom % 4) == 0);
            redirect    = (($urandom % 40) == 0);
            redirect_pc = $urandom;
            imem_gnt    = imem_req && (($urandom % 3) != 0);
            imem_rvalid = pend && (($urandom % 2) == 0);
            imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'd0;

            tests_run++;
            if (imem_req && pend) begin tests_failed++; $display("FAIL rnd_outstanding c=%0d: got req=1 with response pending expected req=0", c); end
            if (!if_valid) begin
                tests_run++;
                if (if_instruction !== NOP) begin tests_failed++; $display("FAIL rnd_nop c=%0d: got %h expected %h", c, if_instruction, NOP); end
            end
            if (redirect) begin
                exp_pc = redirect_pc & ~32'd3;
            end else if (if_valid && !stall) begin
                tests_run++;
                if (if_pc !== exp_pc || if_pc_plus_4 !== exp_pc + 32'd4 || if_instruction !== mem_word(exp_pc)) begin
                    tests_failed++;
                    $display("FAIL rnd_slot c=%0d: got pc=%h pc4=%h instr=%h expected pc=%h instr=%h", c, if_pc, if_pc_plus_4, if_instruction, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end

            if (imem_rvalid) pend = 1'b0;
            if (imem_gnt) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
            end
            tick();
        end
        idle_inputs();
        tests_run++;
        if (consumed < 150) begin tests_failed++; $display("FAIL rnd_progress: got %0d instructions expected at least 150", consumed); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        pend      = 1'b0;
        pend_addr = 32'd0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_gnt();
        test_gnt_delay_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
